// File: rtl/spawn_ctrl.sv
`default_nettype none

`ifndef SPAWN_COUNTER_SIZE
`define SPAWN_COUNTER_SIZE 4
`endif

`ifndef NBR_ENEMIES
`define NBR_ENEMIES 4
`endif

// ============================================================================
// Module   : spawn_ctrl
// Purpose  : Enemy spawn scheduler. After a pseudo-random number of frame
//            ticks, picks a free enemy slot and holds a one-hot spawn
//            request until the enemy logic acknowledges it. Also keeps a
//            saturating count of accepted spawns.
// Ports    :
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   pixel_0_line_0 in   one-cycle frame tick
//   prbs_val       in   [SPAWN_W+N_EN-1:0] random vector {slot prefs, delay}
//   enemy_alive    in   [N_EN-1:0] occupied slot flags
//   game_run       in   gameplay active level
//   spawn_req      out  spawn request, held until spawn_ack
//   spawn_mask     out  [N_EN-1:0] one-hot slot, zero when no request
//   spawn_ack      in   request accepted this cycle (honoured in ISSUE only)
//   spawn_total    out  [7:0] accepted spawns, saturating at 255
//   busy           out  high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module spawn_ctrl #(
  parameter int SPAWN_W = `SPAWN_COUNTER_SIZE,
  parameter int N_EN    = `NBR_ENEMIES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pixel_0_line_0,
  input  logic [SPAWN_W+N_EN-1:0] prbs_val,
  input  logic [N_EN-1:0]         enemy_alive,
  input  logic                    game_run,
  output logic                    spawn_req,
  output logic [N_EN-1:0]         spawn_mask,
  input  logic                    spawn_ack,
  output logic [7:0]              spawn_total,
  output logic                    busy
);

  localparam logic [SPAWN_W-1:0] c_ONE_DLY = {{(SPAWN_W-1){1'b0}}, 1'b1};
  localparam logic [N_EN-1:0]    c_ONE_EN  = {{(N_EN-1){1'b0}}, 1'b1};
  localparam logic [7:0]         c_TOT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_COUNT  = 3'd2,
    S_SELECT = 3'd3,
    S_ISSUE  = 3'd4
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [SPAWN_W-1:0]   r_delay_cnt, w_delay_nxt;
  logic                 r_req,       w_req_nxt;
  logic [N_EN-1:0]      r_mask,      w_mask_nxt;
  logic [7:0]           r_total,     w_total_nxt;

  logic [SPAWN_W-1:0]   w_delay_field;
  logic [N_EN-1:0]      w_free;
  logic [N_EN-1:0]      w_cand;
  logic [N_EN-1:0]      w_cand_pick;
  logic [N_EN-1:0]      w_free_pick;

  assign w_delay_field = prbs_val[SPAWN_W-1:0];
  assign w_free        = ~enemy_alive;
  assign w_cand        = prbs_val[SPAWN_W+N_EN-1:SPAWN_W] & w_free;

  // x & -x isolates the lowest set bit, so both picks are one-hot (or zero)
  // and always a subset of the free slots.
  assign w_cand_pick   = w_cand & (~w_cand + c_ONE_EN);
  assign w_free_pick   = w_free & (~w_free + c_ONE_EN);

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay_cnt;
    w_req_nxt   = r_req;
    w_mask_nxt  = r_mask;
    w_total_nxt = r_total;

    if (!game_run) begin
      // Leaving gameplay wins over everything, including a same-cycle ack.
      w_state_nxt = S_IDLE;
      w_req_nxt   = 1'b0;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
        end
        S_ARM: begin
          if (pixel_0_line_0) begin
            // A zero delay would underflow the countdown; treat it as one.
            w_delay_nxt = (w_delay_field == '0) ? c_ONE_DLY : w_delay_field;
            w_state_nxt = S_COUNT;
          end
        end
        S_COUNT: begin
          if (pixel_0_line_0) begin
            w_delay_nxt = r_delay_cnt - c_ONE_DLY;
            if (r_delay_cnt == c_ONE_DLY) begin
              w_state_nxt = S_SELECT;
            end
          end
        end
        S_SELECT: begin
          // With every slot alive, stay here and retry next cycle.
          if (|w_free) begin
            w_mask_nxt  = (|w_cand) ? w_cand_pick : w_free_pick;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (spawn_ack) begin
            w_req_nxt   = 1'b0;
            w_mask_nxt  = '0;
            w_total_nxt = (r_total == c_TOT_MAX) ? r_total : r_total + 8'd1;
            w_state_nxt = S_ARM;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_mask_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_delay_cnt <= '0;
      r_req       <= 1'b0;
      r_mask      <= '0;
      r_total     <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_delay_cnt <= w_delay_nxt;
      r_req       <= w_req_nxt;
      r_mask      <= w_mask_nxt;
      r_total     <= w_total_nxt;
    end
  end

  assign spawn_req   = r_req;
  assign spawn_mask  = r_mask;
  assign spawn_total = r_total;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spawn_ctrl.sv
`default_nettype none

// ============================================================================
// Module   : tb_spawn_ctrl
// Purpose  : Self-checking bench for spawn_ctrl (SPAWN_W=4, N_EN=4).
//            Directed stimulus pushes the expected {mask, rise cycle} of each
//            spawn request into a queue; a monitor pops and compares when
//            spawn_req rises, and checks mask stability / one-hotness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] prbs = 8'h00;
  logic [3:0] alive = 4'h0;
  logic       run = 1'b0;
  logic       ack = 1'b0;
  logic       req;
  logic [3:0] mask;
  logic [7:0] total;
  logic       busy;

  spawn_ctrl #(.SPAWN_W(4), .N_EN(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pixel_0_line_0 (tick),
    .prbs_val       (prbs),
    .enemy_alive    (alive),
    .game_run       (run),
    .spawn_req      (req),
    .spawn_mask     (mask),
    .spawn_ack      (ack),
    .spawn_total    (total),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_req  = 1'b0;
  logic [3:0] held_mask = 4'h0;

  always @(negedge clk) begin
    if (req && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req_rise", 32'(mask), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("req_mask", 32'(mask), 32'(e.mask));
        chk("req_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
      chk("req_mask_onehot", 32'($countones(mask)), 32'd1);
      held_mask = mask;
    end else if (req && prev_req) begin
      chk("mask_stable", 32'(mask), 32'(held_mask));
    end else if (!req) begin
      chk("mask_zero_idle", 32'(mask), 32'd0);
    end
    prev_req = req;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Final COUNT tick: request expected 2 edges after the tick is driven.
  task automatic last_tick(input logic [3:0] m);
    exp_t e;
    e.mask = m;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    tick_once();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    step(3);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_mask", 32'(mask), 32'd0);
    chk("reset_total", 32'(total), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_without_run_busy", 32'(busy), 32'd0);

    run = 1'b1;
    step(1);
    chk("arm_busy", 32'(busy), 32'd1);

    // A: delay 3, prefs 0110, nothing alive -> slot 0010
    prbs  = 8'b0110_0011;
    alive = 4'b0000;
    tick_once();
    step(2); tick_once();
    step(2); tick_once();
    step(2); last_tick(4'b0010);
    step(2);
    chk("A_req_high", 32'(req), 32'd1);
    step(4);   // request held 5+ cycles without ack
    chk("A_req_held", 32'(req), 32'd1);
    do_ack();
    chk("A_total", 32'(total), 32'd1);
    chk("A_req_cleared", 32'(req), 32'd0);
    chk("A_busy_arm", 32'(busy), 32'd1);
    do_ack();  // ack outside ISSUE is ignored
    step(1);
    chk("ack_outside_issue_total", 32'(total), 32'd1);

    // B: delay field 0 acts as 1; prefs 0101 -> slot 0001
    prbs = 8'b0101_0000;
    tick_once();
    step(1); last_tick(4'b0001);
    step(2);
    do_ack();
    chk("B_total", 32'(total), 32'd2);

    // C: prefs 0011, alive 1011 -> no candidate, fallback to slot 0100
    prbs  = 8'b0011_0001;
    alive = 4'b1011;
    tick_once();
    step(1); tick_once();
    exp_q.push_back('{mask: 4'b0100, cyc: cyc + 1});
    step(2);
    do_ack();
    chk("C_total", 32'(total), 32'd3);

    // D: all slots alive in SELECT for 10 cycles, then slot 3 frees
    alive = 4'b1111;
    tick_once();
    step(1); tick_once();
    step(10);
    chk("D_stall_req_low", 32'(req), 32'd0);
    chk("D_stall_busy", 32'(busy), 32'd1);
    alive = 4'b0111;
    exp_q.push_back('{mask: 4'b1000, cyc: cyc + 1});
    step(2);
    do_ack();
    chk("D_total", 32'(total), 32'd4);

    // E: ack together with game_run low -> IDLE, total unchanged
    prbs  = 8'b0010_0001;
    alive = 4'b0000;
    tick_once();
    step(1); last_tick(4'b0010);
    step(2);
    ack = 1'b1;
    run = 1'b0;
    step(1);
    ack = 1'b0;
    chk("E_req", 32'(req), 32'd0);
    chk("E_mask", 32'(mask), 32'd0);
    chk("E_busy", 32'(busy), 32'd0);
    chk("E_total_kept", 32'(total), 32'd4);

    // F: reset mid-ISSUE clears everything after one edge
    run = 1'b1;
    step(1);
    tick_once();
    step(1); last_tick(4'b0010);
    step(2);
    chk("F_req_before_rst", 32'(req), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("F_req", 32'(req), 32'd0);
    chk("F_mask", 32'(mask), 32'd0);
    chk("F_busy", 32'(busy), 32'd0);
    chk("F_total", 32'(total), 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    step(2);

    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spawn_ctrl.md
SPAWN_CTRL -- requirements
Module: spawn_ctrl

Interface
REQ-001 The block SHALL have parameter SPAWN_W, default `SPAWN_COUNTER_SIZE, the width of the spawn-delay field.
REQ-002 The block SHALL have parameter N_EN, default `NBR_ENEMIES, the number of enemy slots.
REQ-003 clk  input  1  the single system clock.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 pixel_0_line_0  input  1  frame tick, high for one clk at the first pixel of each frame.
REQ-006 prbs_val  input  SPAWN_W+N_EN  pseudo-random vector from the PRBS stage; it advances on the same frame tick.
REQ-007 enemy_alive  input  N_EN  per-slot occupied flags from the enemy logic.
REQ-008 game_run  input  1  level; high while gameplay is active.
REQ-009 spawn_req  output  1  spawn request, held until acknowledged.
REQ-010 spawn_mask  output  N_EN  one-hot slot to spawn; valid while spawn_req is high, zero otherwise.
REQ-011 spawn_ack  input  1  enemy logic accepts the request in this cycle.
REQ-012 spawn_total  output  8  count of accepted spawns; saturates at 255.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have five states: IDLE, ARM, COUNT, SELECT, ISSUE.
REQ-015 On any cycle with game_run low, the FSM SHALL go to IDLE on the next edge; this overrides all other transitions and clears spawn_req and spawn_mask.
REQ-016 In IDLE with game_run high, the FSM SHALL go to ARM on the next edge.
REQ-017 In ARM on a tick cycle, delay_cnt SHALL load prbs_val[SPAWN_W-1:0] as sampled in that cycle (the pre-advance value), or 1 if that field is 0; the FSM SHALL then go to COUNT.
REQ-018 In COUNT on a tick cycle, delay_cnt SHALL decrement by 1; if delay_cnt was 1, the FSM SHALL go to SELECT; non-tick cycles SHALL hold state.
REQ-019 In SELECT, the block SHALL form the candidate set prbs_val[SPAWN_W+N_EN-1:SPAWN_W] AND NOT enemy_alive.
  - Candidate set nonzero: choose its lowest set bit.
  - Candidate set zero and ~enemy_alive nonzero: choose the lowest free slot.
REQ-020 When SELECT chooses a slot, the block SHALL register spawn_mask with that slot, set spawn_req to 1, and go to ISSUE.
REQ-021 If all slots are alive in SELECT, the FSM SHALL remain in SELECT and re-evaluate every cycle, with spawn_req held at 0.
REQ-022 In ISSUE, spawn_req and spawn_mask SHALL be held stable until a cycle with spawn_ack high.
REQ-023 On an ISSUE cycle with spawn_ack high, the next edge SHALL clear spawn_req and spawn_mask, increment spawn_total (saturating at 255), and go to ARM.
REQ-024 spawn_ack received outside ISSUE SHALL be ignored.
REQ-025 If spawn_ack and game_run low occur in the same cycle, game_run SHALL take priority: the FSM goes to IDLE and spawn_total is not incremented.
REQ-026 Latency: spawn_req SHALL rise exactly 2 clk after the tick that moves COUNT to SELECT, provided a free slot exists.
REQ-027 spawn_mask SHALL never have more than one bit set and SHALL never select a slot whose enemy_alive bit was set in the SELECT cycle.
REQ-028 spawn_total SHALL be preserved across IDLE and cleared only by reset.

Reset
REQ-029 With rst_n low at a clk edge, the block SHALL go to IDLE and clear spawn_req, spawn_mask, busy, delay_cnt and spawn_total to 0.
REQ-030 Reset SHALL take priority over every other input, including mid-ISSUE with spawn_req high.

Verification (SPAWN_W=4, N_EN=4)
REQ-031 Scenario: game_run=1, ARM tick with prbs_val=8'b0110_0011, enemy_alive=0 -> after the 3rd subsequent tick plus 2 clk, spawn_req=1 and spawn_mask=4'b0010.
REQ-032 Scenario: delay field 0 -> delay treated as 1; spawn_req rises 2 clk after the first tick following ARM.
REQ-033 Scenario: upper prbs field 4'b0011, enemy_alive=4'b1011 -> spawn_mask=4'b0100 (fallback to lowest free slot).
REQ-034 Scenario: enemy_alive=4'b1111 in SELECT for 10 clk, then 4'b0111 -> spawn_req stays 0 for those 10 clk, then asserts with spawn_mask=4'b1000.
REQ-035 Scenario: spawn_req held 5 clk with no ack, then ack -> mask stable throughout, spawn_total +1, FSM back in ARM.
REQ-036 Scenario: spawn_ack and game_run=0 in the same cycle -> IDLE, spawn_req=0, spawn_total unchanged; separately, rst_n=0 mid-ISSUE -> all outputs 0 after one edge.
